// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON working-memory datapath.
package ascon_pkg;
    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 32;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_t;
endpackage

// File: rtl/mem_arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = 4'd8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/mem_arb.sv
// Single-port working-memory arbiter: engine has priority, Wishbone wins after
// WB_MAX_WAIT consecutive denied cycles so host access is never starved.
module mem_arb
    import ascon_pkg::*;
#(
    parameter int WB_MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [MEM_ADDR_W-1:0] wbs_adr_i,
    input  logic [MEM_DATA_W-1:0] wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [MEM_DATA_W-1:0] wbs_dat_o,
    input  logic                  eng_req,
    input  logic                  eng_we_n,
    input  logic [MEM_ADDR_W-1:0] eng_addr,
    input  logic [MEM_DATA_W-1:0] eng_wdata,
    output logic                  eng_gnt,
    output logic                  eng_rvalid,
    output logic [MEM_DATA_W-1:0] eng_rdata,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_datain,
    input  logic [MEM_DATA_W-1:0] mem_dataout
);
    localparam logic [3:0] MAX_WAIT = 4'(WB_MAX_WAIT);

    wb_state_t  state_d;
    wb_state_t  state_q;
    logic       eng_rvalid_d;
    logic       eng_rvalid_q;
    logic [3:0] wait_cnt;
    logic       wb_pend;
    logic       eng_win;
    logic       wb_win;

    // Wishbone is ineligible during WB_ACK because stb is still high then.
    assign wb_pend = wbs_cyc_i & wbs_stb_i & (state_q == WB_IDLE);

    always_comb begin
        eng_win      = nRST & eng_req & ~(wb_pend & (wait_cnt >= MAX_WAIT));
        wb_win       = nRST & ~eng_win & wb_pend;
        mem_we       = 1'b1;
        mem_addr     = '0;
        mem_datain   = '0;
        if (eng_win) begin
            mem_we     = eng_we_n;
            mem_addr   = eng_addr;
            mem_datain = eng_wdata;
        end else if (wb_win) begin
            mem_we     = ~wbs_we_i;
            mem_addr   = wbs_adr_i;
            mem_datain = wbs_dat_i;
        end
        eng_rvalid_d = eng_win & eng_we_n;
        state_d      = state_q;
        if (wb_win) begin
            state_d = WB_ACK;
        end else if (state_q == WB_ACK) begin
            state_d = WB_IDLE;
        end
    end

    sat_counter #(
        .WIDTH (4),
        .MAX   (MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (nRST),
        .inc   (wb_pend & eng_win),
        .clr   (wb_win | ~wb_pend),
        .cnt   (wait_cnt)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= WB_IDLE;
            eng_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            eng_rvalid_q <= eng_rvalid_d;
        end
    end

    assign eng_gnt    = eng_win;
    assign eng_rvalid = eng_rvalid_q;
    assign eng_rdata  = mem_dataout;
    assign wbs_ack_o  = (state_q == WB_ACK) & wbs_cyc_i;
    assign wbs_dat_o  = (state_q == WB_ACK) ? mem_dataout : '0;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural 1-cycle-latency SRAM and
// read-data scoreboards for both ports.
module tb_mem_arb;
    logic        clk = 1'b0;
    logic        nRST;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [4:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        eng_req, eng_we_n;
    logic [4:0]  eng_addr;
    logic [31:0] eng_wdata;
    logic        eng_gnt, eng_rvalid;
    logic [31:0] eng_rdata;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    logic [31:0] sram [32];
    logic [31:0] wb_q[$];
    logic [31:0] eng_q[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_we) sram[mem_addr] <= mem_datain;
        mem_dataout <= sram[mem_addr];
    end

    mem_arb #(.WB_MAX_WAIT(8)) dut (
        .clk(clk), .nRST(nRST),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .eng_req(eng_req), .eng_we_n(eng_we_n), .eng_addr(eng_addr),
        .eng_wdata(eng_wdata), .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid),
        .eng_rdata(eng_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_datain(mem_datain),
        .mem_dataout(mem_dataout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb_pop(input string tag);
        logic [31:0] exp;
        if (wb_q.size() == 0) begin
            n_vec++; n_err++;
            $error("FAIL %s: got %h want <queued read>", tag, wbs_dat_o);
        end else begin
            exp = wb_q.pop_front();
            chk(tag, wbs_dat_o, exp);
        end
    endtask

    task automatic chk_eng_pop(input string tag);
        logic [31:0] exp;
        if (eng_q.size() == 0) begin
            n_vec++; n_err++;
            $error("FAIL %s: got %h want <queued read>", tag, eng_rdata);
        end else begin
            exp = eng_q.pop_front();
            chk(tag, eng_rdata, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_drive(input logic we, input logic [4:0] adr, input logic [31:0] dat);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;
    endtask

    task automatic wb_idle();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_adr_i = '0;   wbs_dat_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset with requests driven: grants must be suppressed
        nRST = 1'b0;
        wb_drive(1'b1, 5'd9, 32'h1111_1111);
        eng_req = 1'b1; eng_we_n = 1'b0; eng_addr = 5'd4; eng_wdata = 32'h2222_2222;
        #12;
        chk("rst_ack",    {31'd0, wbs_ack_o},  32'd0);
        chk("rst_rvalid", {31'd0, eng_rvalid}, 32'd0);
        chk("rst_dat_o",  wbs_dat_o,           32'd0);
        chk("rst_gnt",    {31'd0, eng_gnt},    32'd0);
        chk("rst_mem_we", {31'd0, mem_we},     32'd1);
        chk("rst_addr",   {27'd0, mem_addr},   32'd0);
        wb_idle();
        eng_req = 1'b0; eng_we_n = 1'b1; eng_addr = '0; eng_wdata = '0;
        #1 nRST = 1'b1;
        tick();

        // uncontended Wishbone write then read
        wb_drive(1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        chk("wbw_mem_we", {31'd0, mem_we},   32'd0);
        chk("wbw_addr",   {27'd0, mem_addr}, 32'd5);
        chk("wbw_din",    mem_datain,        32'hDEAD_BEEF);
        chk("wbw_noack",  {31'd0, wbs_ack_o}, 32'd0);
        tick();
        chk("wbw_ack",    {31'd0, wbs_ack_o}, 32'd1);
        chk("wbw_ack_we", {31'd0, mem_we},   32'd1);
        wb_idle();
        tick();
        chk("wbw_ack_end", {31'd0, wbs_ack_o}, 32'd0);
        wb_drive(1'b0, 5'd5, 32'd0);
        wb_q.push_back(32'hDEAD_BEEF);
        #1;
        chk("wbr_mem_we", {31'd0, mem_we},   32'd1);
        chk("wbr_addr",   {27'd0, mem_addr}, 32'd5);
        tick();
        chk("wbr_ack", {31'd0, wbs_ack_o}, 32'd1);
        chk_wb_pop("wbr_data");
        wb_idle();
        tick();

        // engine write then read of addr 3
        eng_req = 1'b1; eng_we_n = 1'b0; eng_addr = 5'd3; eng_wdata = 32'h1234_5678;
        #1;
        chk("engw_gnt", {31'd0, eng_gnt}, 32'd1);
        chk("engw_we",  {31'd0, mem_we},  32'd0);
        tick();
        chk("engw_norv", {31'd0, eng_rvalid}, 32'd0);
        eng_we_n = 1'b1; eng_wdata = '0;
        eng_q.push_back(32'h1234_5678);
        #1;
        chk("engr_gnt", {31'd0, eng_gnt}, 32'd1);
        tick();
        eng_req = 1'b0;
        chk("engr_rv", {31'd0, eng_rvalid}, 32'd1);
        chk_eng_pop("engr_data");
        tick();
        chk("engr_rv_end", {31'd0, eng_rvalid}, 32'd0);

        // continuous engine reads vs a Wishbone read: WB wins on cycle 8
        eng_req = 1'b1; eng_we_n = 1'b1; eng_addr = 5'd1;
        wb_drive(1'b0, 5'd5, 32'd0);
        wb_q.push_back(32'hDEAD_BEEF);
        #1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("starve_gnt%0d", c), {31'd0, eng_gnt}, 32'd1);
            if (c > 0) chk($sformatf("starve_rv%0d", c), {31'd0, eng_rvalid}, 32'd1);
            tick();
        end
        chk("starve_wb_gnt", {31'd0, eng_gnt},  32'd0);
        chk("starve_wb_adr", {27'd0, mem_addr}, 32'd5);
        chk("starve_noack",  {31'd0, wbs_ack_o}, 32'd0);
        tick();
        chk("starve_ack",     {31'd0, wbs_ack_o}, 32'd1);
        chk_wb_pop("starve_data");
        chk("starve_eng_back", {31'd0, eng_gnt},    32'd1);
        chk("starve_rv_gap",   {31'd0, eng_rvalid}, 32'd0);
        wb_idle(); eng_req = 1'b0;
        tick();

        // wait count clears when the strobe drops before saturation
        eng_req = 1'b1;
        wb_drive(1'b0, 5'd5, 32'd0);
        #1;
        chk("clr_first_eng", {31'd0, eng_gnt}, 32'd1);
        tick();
        wbs_stb_i = 1'b0;
        tick();
        wbs_stb_i = 1'b1;
        wb_q.push_back(32'hDEAD_BEEF);
        #1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("clr_gnt%0d", c), {31'd0, eng_gnt}, 32'd1);
            tick();
        end
        chk("clr_wb_win", {31'd0, eng_gnt}, 32'd0);
        tick();
        chk("clr_ack", {31'd0, wbs_ack_o}, 32'd1);
        chk_wb_pop("clr_data");
        wb_idle(); eng_req = 1'b0;
        tick();

        // cyc dropped during ack: write still lands, ack suppressed
        wb_drive(1'b1, 5'd7, 32'hA5A5_A5A5);
        tick();
        wb_idle();
        #1;
        chk("drop_noack", {31'd0, wbs_ack_o}, 32'd0);
        tick();
        wb_drive(1'b0, 5'd7, 32'd0);
        wb_q.push_back(32'hA5A5_A5A5);
        #1;
        chk("drop_next_gnt", {27'd0, mem_addr}, 32'd7);
        tick();
        chk("drop_next_ack", {31'd0, wbs_ack_o}, 32'd1);
        chk_wb_pop("drop_next_data");
        wb_idle();
        tick();

        // reset during WB_ACK
        wb_drive(1'b0, 5'd5, 32'd0);
        tick();
        chk("rack_pre", {31'd0, wbs_ack_o}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("rack_ack",    {31'd0, wbs_ack_o}, 32'd0);
        chk("rack_dat_o",  wbs_dat_o,          32'd0);
        chk("rack_mem_we", {31'd0, mem_we},    32'd1);
        chk("rack_addr",   {27'd0, mem_addr},  32'd0);
        wb_idle();
        #2 nRST = 1'b1;
        tick();

        // reset after an engine read grant
        eng_req = 1'b1; eng_we_n = 1'b1; eng_addr = 5'd3;
        eng_q.push_back(32'h1234_5678);
        tick();
        eng_req = 1'b0;
        chk("rrv_pre", {31'd0, eng_rvalid}, 32'd1);
        chk_eng_pop("rrv_data");
        nRST = 1'b0;
        #1;
        chk("rrv_rv",     {31'd0, eng_rvalid}, 32'd0);
        chk("rrv_mem_we", {31'd0, mem_we},     32'd1);
        #2 nRST = 1'b1;
        tick();
        chk("rrv_noreplay", {31'd0, wbs_ack_o}, 32'd0);

        // normal operation resumes
        wb_drive(1'b0, 5'd5, 32'd0);
        wb_q.push_back(32'hDEAD_BEEF);
        tick();
        chk("post_ack", {31'd0, wbs_ack_o}, 32'd1);
        chk_wb_pop("post_data");
        wb_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
